// File: rtl/multi_serial_pkg.sv
// Shared constants and types for the serial product deserializer.
package multi_serial_pkg;

  localparam int OPND_W = 4;
  localparam int PROD_W = 2 * OPND_W;
  localparam int CNT_W  = $clog2(PROD_W) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } frame_state_t;

  // Bit counter width for a given product width.
  function automatic int cnt_width(input int prod_w);
    return $clog2(prod_w) + 1;
  endfunction

endpackage

// File: rtl/sipo_frame_shifter.sv
// Serial-in parallel-out frame assembler. Collects PROD_W LSB-first bits
// framed by sync, restarts on a sync that lands mid-frame (abort), and
// emits a one-cycle done pulse together with the completed word.
module sipo_frame_shifter
  import multi_serial_pkg::*;
#(
  parameter int PROD_W = multi_serial_pkg::PROD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ser_in,
  input  logic              sync,
  output logic              done,
  output logic [PROD_W-1:0] word,
  output logic              abort,
  output frame_state_t      state
);

  localparam int CW = cnt_width(PROD_W);
  localparam logic [CW-1:0] LAST_IDX = CW'(PROD_W - 1);

  frame_state_t      state_d;
  logic [PROD_W-1:0] sr;
  logic [CW-1:0]     cnt;
  logic              load_first;
  logic              shift_en;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, frame start/abort decode and completion pulse.
  // word is the shift register as it will look after this cycle's bit,
  // so it is only meaningful while done is high.
  always_comb begin
    state_d    = state;
    done       = 1'b0;
    abort      = 1'b0;
    load_first = 1'b0;
    shift_en   = 1'b0;
    word       = {ser_in, sr[PROD_W-1:1]};
    case (state)
      IDLE: begin
        if (sync) begin
          load_first = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (sync) begin
          abort      = 1'b1;
          load_first = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (cnt == LAST_IDX) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register and bit counter. Bits enter at the MSB and move right,
  // so bit 0 (captured with sync) ends up in word[0] after PROD_W bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load_first) begin
      sr  <= {ser_in, {(PROD_W-1){1'b0}}};
      cnt <= CW'(1);
    end else if (shift_en) begin
      sr  <= {ser_in, sr[PROD_W-1:1]};
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multi_serial_product_deser.sv
// Deserializer for the bit-serial multiplier product stream: assembles
// LSB-first frames into parallel words, holds one word for the consumer
// and keeps sticky overflow / framing error flags.
//
// Output handshake: P_VALID high means P_DATA holds an unconsumed word;
// a transfer happens at a CLK edge where P_VALID and P_READY are both high.
// P_DATA does not change while P_VALID=1 and P_READY=0. A completing frame
// may load in the same edge that the held word is consumed.
module multi_serial_product_deser
  import multi_serial_pkg::*;
#(
  parameter int PROD_W = multi_serial_pkg::PROD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SER_IN,
  input  logic              SYNC,
  output logic [PROD_W-1:0] P_DATA,
  output logic              P_VALID,
  input  logic              P_READY,
  output logic              OVF,
  output logic              FRAME_ERR,
  input  logic              CLR_ERR
);

  logic              frame_done;
  logic [PROD_W-1:0] frame_word;
  logic              frame_abort;
  frame_state_t      frame_state;
  logic              hold_free;

  sipo_frame_shifter #(.PROD_W(PROD_W)) u_shifter (
    .CLK    (CLK),
    .RST    (RST),
    .ser_in (SER_IN),
    .sync   (SYNC),
    .done   (frame_done),
    .word   (frame_word),
    .abort  (frame_abort),
    .state  (frame_state)
  );

  // The holding register can take a new word if empty or being consumed now.
  assign hold_free = !P_VALID || P_READY;

  // Holding register and valid flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA  <= '0;
      P_VALID <= 1'b0;
    end else if (frame_done && hold_free) begin
      P_DATA  <= frame_word;
      P_VALID <= 1'b1;
    end else if (P_VALID && P_READY) begin
      P_VALID <= 1'b0;
    end
  end

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF       <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      if (frame_done && !hold_free) OVF <= 1'b1;
      else if (CLR_ERR)             OVF <= 1'b0;
      if (frame_abort && frame_state == SHIFT) FRAME_ERR <= 1'b1;
      else if (CLR_ERR)                         FRAME_ERR <= 1'b0;
    end
  end

endmodule
